// File: rtl/bundler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bundler_pkg
// Description : Shared types and helpers for the streaming majority bundler.
// Revision    : 1.0 - initial release
// ============================================================================
package bundler_pkg;

    typedef enum logic [1:0] {
        TIE_ZERO = 2'd0,
        TIE_ONE  = 2'd1,
        TIE_HV   = 2'd2
    } tie_mode_e;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        THRESH = 2'd1,
        DONE   = 2'd2
    } state_e;

    // Counter width able to hold 0..max_hvs inclusive.
    function automatic int cnt_width(input int max_hvs);
        return (max_hvs < 1) ? 1 : $clog2(max_hvs + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/majority_slice.sv
`default_nettype none
// ============================================================================
// Module      : majority_slice
// Description : Combinational PAR_BITS-wide majority threshold with tie-break.
// Revision    : 1.0 - initial release
// ============================================================================
module majority_slice
    import bundler_pkg::*;
#(
    parameter int PAR_BITS = 8,
    parameter int CW       = 7
) (
    input  logic [PAR_BITS-1:0][CW-1:0] i_cnt,
    input  logic [CW-1:0]               i_n,
    input  logic [PAR_BITS-1:0]         i_tie,
    input  logic [1:0]                  i_mode,
    output logic [PAR_BITS-1:0]         o_bits
);

    // One extra bit so that 2*cnt cannot wrap.
    logic [CW:0] w_n_ext;
    assign w_n_ext = {1'b0, i_n};

    for (genvar gi = 0; gi < PAR_BITS; gi++) begin : g_bit
        logic [CW:0] w_twice;
        logic        w_tie_bit;
        assign w_twice   = {i_cnt[gi], 1'b0};
        // Reserved mode 3 falls through to zero.
        assign w_tie_bit = (i_mode == TIE_ONE) | ((i_mode == TIE_HV) & i_tie[gi]);
        assign o_bits[gi] = (w_twice > w_n_ext) ? 1'b1 :
                            (w_twice < w_n_ext) ? 1'b0 : w_tie_bit;
    end

endmodule
`default_nettype wire

// File: rtl/bundler_acc.sv
`default_nettype none
// ============================================================================
// Module      : bundler_acc
// Description : Streaming majority bundler: accumulates a variable-length set
//               of hypervectors, then thresholds PAR_BITS dimensions per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module bundler_acc
    import bundler_pkg::*;
#(
    parameter int DIMENSIONS = 1024,
    parameter int MAX_HVS    = 64,
    parameter int PAR_BITS   = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               hv_valid,
    output logic                               hv_ready,
    input  logic [DIMENSIONS-1:0]              hv_in,
    input  logic                               last,
    input  logic [1:0]                         tie_mode,
    input  logic [DIMENSIONS-1:0]              tie_hv,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [DIMENSIONS-1:0]              hv_out,
    output logic [cnt_width(MAX_HVS)-1:0]      hv_count,
    output logic                               truncated
);

    localparam int c_cw = cnt_width(MAX_HVS);
    localparam int c_k  = DIMENSIONS / PAR_BITS;
    localparam int c_kw = (c_k > 1) ? $clog2(c_k) : 1;
    localparam int c_dw = (DIMENSIONS > 1) ? $clog2(DIMENSIONS) : 1;

    if (DIMENSIONS % PAR_BITS != 0) begin : g_bad_par_bits
        $error("bundler_acc: DIMENSIONS must be a multiple of PAR_BITS");
    end
    if (MAX_HVS < 1) begin : g_bad_max_hvs
        $error("bundler_acc: MAX_HVS must be at least 1");
    end

    state_e                 r_state;
    logic [c_cw-1:0]        r_cnt [DIMENSIONS];
    logic [c_cw-1:0]        r_n;
    logic [c_kw-1:0]        r_chunk;
    logic [DIMENSIONS-1:0]  r_hv_out;
    logic [1:0]             r_tie_mode;
    logic [DIMENSIONS-1:0]  r_tie_hv;
    logic                   r_trunc;
    logic                   r_out_valid;

    logic [c_dw-1:0]                  w_base;
    logic [PAR_BITS-1:0][c_cw-1:0]    w_cnt_slice;
    logic [PAR_BITS-1:0]              w_tie_slice;
    logic [PAR_BITS-1:0]              w_bits;
    logic                             w_close;

    assign w_base = c_dw'(r_chunk) * c_dw'(PAR_BITS);

    // A single comparator is shared across chunks; the counters are muxed in.
    always_comb begin
        w_cnt_slice = '0;
        for (int i = 0; i < PAR_BITS; i++) begin
            w_cnt_slice[i] = r_cnt[w_base + c_dw'(i)];
        end
    end
    assign w_tie_slice = r_tie_hv[w_base +: PAR_BITS];

    majority_slice #(
        .PAR_BITS (PAR_BITS),
        .CW       (c_cw)
    ) u_slice (
        .i_cnt  (w_cnt_slice),
        .i_n    (r_n),
        .i_tie  (w_tie_slice),
        .i_mode (r_tie_mode),
        .o_bits (w_bits)
    );

    assign w_close = last || ((r_n + c_cw'(1)) == c_cw'(MAX_HVS));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ACCUM;
            for (int d = 0; d < DIMENSIONS; d++) r_cnt[d] <= '0;
            r_n         <= '0;
            r_chunk     <= '0;
            r_hv_out    <= '0;
            r_tie_mode  <= '0;
            r_tie_hv    <= '0;
            r_trunc     <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (hv_valid) begin
                        for (int d = 0; d < DIMENSIONS; d++) begin
                            r_cnt[d] <= r_cnt[d] + c_cw'(hv_in[d]);
                        end
                        r_n <= r_n + c_cw'(1);
                        if (w_close) begin
                            r_tie_mode <= tie_mode;
                            r_tie_hv   <= tie_hv;
                            r_trunc    <= !last;
                            r_chunk    <= '0;
                            r_state    <= THRESH;
                        end
                    end
                end
                THRESH: begin
                    r_hv_out[w_base +: PAR_BITS] <= w_bits;
                    if (r_chunk == c_kw'(c_k - 1)) begin
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_chunk <= r_chunk + c_kw'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        for (int d = 0; d < DIMENSIONS; d++) r_cnt[d] <= '0;
                        r_n         <= '0;
                        r_out_valid <= 1'b0;
                        r_state     <= ACCUM;
                    end
                end
                default: r_state <= ACCUM;
            endcase
        end
    end

    // Ready is held low while reset is asserted so no beat looks accepted.
    assign hv_ready  = (r_state == ACCUM) && !rst;
    assign out_valid = r_out_valid;
    assign hv_out    = r_hv_out;
    assign hv_count  = r_n;
    assign truncated = r_trunc;

endmodule
`default_nettype wire

// File: tb/tb_bundler_acc.sv
`default_nettype none
// ============================================================================
// Module      : tb_bundler_acc
// Description : Directed self-checking bench for bundler_acc with a set-level
//               majority model (DIMENSIONS=6, PAR_BITS=2, MAX_HVS=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bundler_acc;

    localparam int D  = 6;
    localparam int MX = 8;
    localparam int P  = 2;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          hv_valid = 1'b0;
    logic          hv_ready;
    logic [D-1:0]  hv_in = '0;
    logic          last = 1'b0;
    logic [1:0]    tie_mode = '0;
    logic [D-1:0]  tie_hv = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [D-1:0]  hv_out;
    logic [CW-1:0] hv_count;
    logic          truncated;

    bundler_acc #(.DIMENSIONS(D), .MAX_HVS(MX), .PAR_BITS(P)) dut (
        .clk(clk), .rst(rst), .hv_valid(hv_valid), .hv_ready(hv_ready),
        .hv_in(hv_in), .last(last), .tie_mode(tie_mode), .tie_hv(tie_hv),
        .out_valid(out_valid), .out_ready(out_ready), .hv_out(hv_out),
        .hv_count(hv_count), .truncated(truncated)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- set-level reference model ----------------
    typedef struct {
        logic [D-1:0] hv;
        int           cnt;
        bit           tr;
    } res_t;

    logic [D-1:0] set_q[$];
    res_t         exp_q[$];
    logic [D-1:0] hs_log[$];

    function automatic res_t bundle(input logic [1:0] tm, input logic [D-1:0] th, input bit tr);
        res_t r;
        int   n = set_q.size();
        r.cnt = n;
        r.tr  = tr;
        for (int d = 0; d < D; d++) begin
            int ones = 0;
            foreach (set_q[i]) ones += set_q[i][d];
            if (2 * ones > n)      r.hv[d] = 1'b1;
            else if (2 * ones < n) r.hv[d] = 1'b0;
            else if (tm == 2'd1)   r.hv[d] = 1'b1;
            else if (tm == 2'd2)   r.hv[d] = th[d];
            else                   r.hv[d] = 1'b0;
        end
        return r;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            set_q.delete();
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                hs_log.push_back(hv_out);
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (hv_valid && hv_ready) begin
                set_q.push_back(hv_in);
                if (last || set_q.size() == MX) begin
                    exp_q.push_back(bundle(tie_mode, tie_hv, !last));
                    set_q.delete();
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out_valid", 32'(out_valid), 32'd0);
            end else begin
                chk("model_hv_out",    32'(hv_out),    32'(exp_q[0].hv));
                chk("model_hv_count",  32'(hv_count),  32'(exp_q[0].cnt));
                chk("model_truncated", 32'(truncated), 32'(exp_q[0].tr));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    int acc_cyc;

    task automatic send(input logic [D-1:0] v, input logic lst, input logic [1:0] tm,
                        input logic [D-1:0] th);
        int   w   = 0;
        logic acc = 1'b0;
        hv_valid = 1'b1; hv_in = v; last = lst; tie_mode = tm; tie_hv = th;
        while (!acc && w < 50) begin
            @(negedge clk);
            acc = hv_ready;
            @(posedge clk);
            #1;
            w++;
        end
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
        acc_cyc  = cyc;
        hv_valid = 1'b0;
        last     = 1'b0;
    endtask

    task automatic wait_out(output int w);
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!out_valid && w < 50);
        if (!out_valid) chk("out_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic expect_res(input string name, input logic [D-1:0] hv,
                              input int cnt, input logic tr);
        chk({name, "_hv_out"},    32'(hv_out),    32'(hv));
        chk({name, "_hv_count"},  32'(hv_count),  32'(cnt));
        chk({name, "_truncated"}, 32'(truncated), 32'(tr));
    endtask

    task automatic send_base5(input logic lst5);
        send(6'b001101, 1'b0, 2'd1, 6'b111111);
        send(6'b000111, 1'b0, 2'd1, 6'b111111);
        send(6'b001111, 1'b0, 2'd1, 6'b111111);
        send(6'b100011, 1'b0, 2'd1, 6'b111111);
        send(6'b100011, lst5, 2'd0, 6'b000000);
    endtask

    task automatic even_set(input logic [1:0] tm, input logic [D-1:0] th,
                            input string name, input logic [D-1:0] exp_hv);
        int w;
        send_base5(1'b0);
        send(6'b111011, 1'b1, tm, th);
        wait_out(w);
        expect_res(name, exp_hv, 6, 1'b0);
        handshake();
    endtask

    initial begin
        int w;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_hv_out",    32'(hv_out),    32'd0);
        chk("rst_hv_count",  32'(hv_count),  32'd0);
        chk("rst_truncated", 32'(truncated), 32'd0);
        chk("rst_hv_ready",  32'(hv_ready),  32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_hv_ready", 32'(hv_ready), 32'd1);
        @(posedge clk);
        #1;

        // Odd set, with latency measured from the closing edge
        send_base5(1'b1);
        wait_out(w);
        chk("latency_negedges", 32'(w), 32'd4);
        expect_res("odd", 6'b000111, 5, 1'b0);

        // Backpressure: result held, input ignored
        hv_valid = 1'b1; hv_in = 6'b111111; last = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_hv_ready",  32'(hv_ready),  32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_hv_out",    32'(hv_out),    32'(6'b000111));
        end
        hv_valid = 1'b0; last = 1'b0;
        @(posedge clk);
        #1;
        handshake();
        @(negedge clk);
        chk("post_hs_ready", 32'(hv_ready), 32'd1);
        @(posedge clk);
        #1;

        // Even sets with ties
        even_set(2'd0, 6'b000000, "tie_zero", 6'b000011);
        even_set(2'd1, 6'b000000, "tie_one",  6'b101111);
        even_set(2'd2, 6'b100000, "tie_hv",   6'b100011);
        even_set(2'd3, 6'b111111, "tie_rsvd", 6'b000011);

        // Truncation at MAX_HVS
        repeat (MX) send(6'b000001, 1'b0, 2'd0, 6'b000000);
        wait_out(w);
        expect_res("trunc", 6'b000001, 8, 1'b1);
        handshake();

        // Reset mid-accumulation discards partial counts
        repeat (3) send(6'b110111, 1'b0, 2'd0, 6'b000000);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_hv_out",    32'(hv_out),    32'd0);
        chk("midrst_hv_count",  32'(hv_count),  32'd0);
        chk("midrst_truncated", 32'(truncated), 32'd0);
        chk("midrst_hv_ready",  32'(hv_ready),  32'd0);
        rst = 1'b0;
        send(6'b101010, 1'b1, 2'd0, 6'b000000);
        wait_out(w);
        expect_res("after_rst", 6'b101010, 1, 1'b0);
        handshake();

        // Back-to-back single-HV sets with out_ready held high
        begin
            int a1;
            int n0;
            n0 = hs_log.size();
            out_ready = 1'b1;
            send(6'b110000, 1'b1, 2'd0, 6'b000000);
            a1 = acc_cyc;
            send(6'b000011, 1'b1, 2'd0, 6'b000000);
            chk("b2b_period", 32'(acc_cyc - a1), 32'd5);
            wait_out(w);
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            chk("b2b_results", 32'(hs_log.size() - n0), 32'd2);
            if (hs_log.size() >= n0 + 2) begin
                chk("b2b_first",  32'(hs_log[n0]),     32'(6'b110000));
                chk("b2b_second", 32'(hs_log[n0 + 1]), 32'(6'b000011));
            end
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
